// File: rtl/stack_mask_sequencer_if.sv
// Stack transfer bus between the mask sequencer (master) and memory (slave).
// Signals:
//   bus_req   master->slave  transfer request
//   bus_we    master->slave  1 = write (push), 0 = read (pop)
//   bus_addr  master->slave  transfer address
//   bus_wdata master->slave  write data
//   bus_rdata slave->master  read data, valid with bus_ack
//   bus_ack   slave->master  transfer complete
interface stack_mask_sequencer_if #(
  parameter int unsigned SP_W   = 16,
  parameter int unsigned DATA_W = 16
);
  logic              bus_req;
  logic              bus_we;
  logic [SP_W-1:0]   bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/stack_mask_sequencer.sv
// Multi-register stack transfer engine (PUSH R / POP R, interrupt entry, RETI).
// Walks the push mask lowest-bit-first, then the pop mask highest-bit-first,
// issuing one word transfer per set bit and tracking a working SP.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start                    launch (sampled in IDLE only)
//   push_mask, pop_mask      slot masks, latched on accepted start
//   sp_in                    initial SP, latched on accepted start
//   busy, done               sequence in progress / one-cycle completion pulse
//   sp_out                   working SP
//   slot                     current register-file slot
//   push_data                register-file read data for slot
//   reg_we, reg_wdata        register-file write strobe/data for pops
//   bus                      transfer bus (master modport)
//   sp_wrapped               sticky SP wrap flag for the current sequence
// Optional feature: define STACK_SEQ_WRAP_FLAG_EN to build wrap detection;
// otherwise sp_wrapped is tied low.
module stack_mask_sequencer #(
  parameter int unsigned MASK_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SP_W        = 16,
  parameter int unsigned DISCARD_BIT = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [MASK_W-1:0]        push_mask,
  input  logic [MASK_W-1:0]        pop_mask,
  input  logic [SP_W-1:0]          sp_in,
  output logic                     busy,
  output logic                     done,
  output logic [SP_W-1:0]          sp_out,
  output logic [$clog2(MASK_W)-1:0] slot,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     reg_we,
  output logic [DATA_W-1:0]        reg_wdata,
  stack_mask_sequencer_if.master   bus,
  output logic                     sp_wrapped
);

  localparam int unsigned SLOT_W = $clog2(MASK_W);
  localparam logic [SP_W-1:0] STEP = SP_W'(DATA_W / 8);
  localparam logic [SLOT_W-1:0] DISCARD_SLOT = SLOT_W'(DISCARD_BIT);

  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_DONE} state_t;

  state_t            state, state_nx;
  logic [MASK_W-1:0] push_rem, push_rem_nx;
  logic [MASK_W-1:0] pop_rem, pop_rem_nx;
  logic [SP_W-1:0]   sp_q, sp_nx;
  logic [SLOT_W-1:0] lo_idx, hi_idx;
  logic              in_push, in_pop;

  // Lowest set bit of the remaining push mask.
  always_comb begin
    lo_idx = '0;
    for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
      if (push_rem[i]) lo_idx = SLOT_W'(i);
    end
  end

  // Highest set bit of the remaining pop mask.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (pop_rem[i]) hi_idx = SLOT_W'(i);
    end
  end

  assign in_push = (state == S_PUSH);
  assign in_pop  = (state == S_POP);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      push_rem <= '0;
      pop_rem  <= '0;
      sp_q     <= '0;
    end else begin
      state    <= state_nx;
      push_rem <= push_rem_nx;
      pop_rem  <= pop_rem_nx;
      sp_q     <= sp_nx;
    end
  end

  // Next-state and datapath update; only an ack in PUSH/POP advances a transfer.
  always_comb begin
    state_nx    = state;
    push_rem_nx = push_rem;
    pop_rem_nx  = pop_rem;
    sp_nx       = sp_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          push_rem_nx = push_mask;
          pop_rem_nx  = pop_mask;
          sp_nx       = sp_in;
          if (push_mask != '0)     state_nx = S_PUSH;
          else if (pop_mask != '0) state_nx = S_POP;
          else                     state_nx = S_DONE;
        end
      end
      S_PUSH: begin
        if (bus.bus_ack) begin
          sp_nx       = sp_q - STEP;
          push_rem_nx = push_rem & ~(MASK_W'(1) << lo_idx);
          if (push_rem_nx == '0) state_nx = (pop_rem != '0) ? S_POP : S_DONE;
        end
      end
      S_POP: begin
        if (bus.bus_ack) begin
          sp_nx      = sp_q + STEP;
          pop_rem_nx = pop_rem & ~(MASK_W'(1) << hi_idx);
          if (pop_rem_nx == '0) state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decode directly from the registered state, so they are stable
  // for the whole wait on an ack.
  assign busy          = in_push | in_pop;
  assign done          = (state == S_DONE);
  assign sp_out        = sp_q;
  assign slot          = in_push ? lo_idx : (in_pop ? hi_idx : '0);
  assign bus.bus_req   = in_push | in_pop;
  assign bus.bus_we    = in_push;
  assign bus.bus_addr  = in_push ? (sp_q - STEP) : sp_q;
  assign bus.bus_wdata = push_data;
  assign reg_wdata     = bus.bus_rdata;
  // Pop write strobe is combinational with ack; the discard slot only moves SP.
  assign reg_we        = in_pop & bus.bus_ack & (hi_idx != DISCARD_SLOT);

`ifdef STACK_SEQ_WRAP_FLAG_EN
  logic          wrap_q, wrap_nx;
  logic [SP_W:0] pop_sum;

  assign pop_sum = {1'b0, sp_q} + {1'b0, STEP};

  // Sticky: set when an SP update crosses zero in either direction.
  always_comb begin
    wrap_nx = wrap_q;
    if (state == S_IDLE && start)              wrap_nx = 1'b0;
    else if (in_push && bus.bus_ack && sp_q < STEP) wrap_nx = 1'b1;
    else if (in_pop && bus.bus_ack && pop_sum[SP_W]) wrap_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap_q <= 1'b0;
    else          wrap_q <= wrap_nx;
  end

  assign sp_wrapped = wrap_q;
`else
  assign sp_wrapped = 1'b0;
`endif

endmodule

// File: tb/tb_stack_mask_sequencer.sv
// Self-checking bench for stack_mask_sequencer: directed test-plan sequences
// plus randomized masks/SP/ack delays against a transfer-list reference model.
module tb_stack_mask_sequencer;
  localparam int unsigned MASK_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned SP_W        = 16;
  localparam int unsigned DISCARD_BIT = 5;
  localparam int          STEP        = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [MASK_W-1:0] push_mask = '0;
  logic [MASK_W-1:0] pop_mask = '0;
  logic [SP_W-1:0]   sp_in = '0;
  logic              busy, done, reg_we, sp_wrapped;
  logic [SP_W-1:0]   sp_out;
  logic [3:0]        slot;
  logic [DATA_W-1:0] push_data, reg_wdata;
  logic [DATA_W-1:0] rf [MASK_W];

  int n_checks = 0;
  int n_fail   = 0;

  stack_mask_sequencer_if #(.SP_W(SP_W), .DATA_W(DATA_W)) bus ();

  stack_mask_sequencer #(
    .MASK_W(MASK_W), .DATA_W(DATA_W), .SP_W(SP_W), .DISCARD_BIT(DISCARD_BIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in),
    .busy(busy), .done(done), .sp_out(sp_out), .slot(slot),
    .push_data(push_data), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .bus(bus), .sp_wrapped(sp_wrapped)
  );

  always #5 clk = ~clk;

  assign push_data = rf[slot];

  typedef struct {
    int slot;
    bit we;
    int addr;
    int dly;
  } xfer_t;

  xfer_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Build the expected transfer list, then drive one sequence and check it.
  task automatic run_seq(input logic [15:0] pm, input logic [15:0] pp,
                         input logic [15:0] sp0, input int dly,
                         input bit rnd_dly, input bit noise);
    int    sp, total, done_at, waited;
    bit    wr, finished;
    xfer_t x;
    q.delete();
    sp = int'(sp0); wr = 0; total = 0;
    for (int i = 0; i < 16; i++) begin
      if (pm[i]) begin
        if (sp < STEP) wr = 1;
        sp = (sp - STEP) & 32'hFFFF;
        x.slot = i; x.we = 1; x.addr = sp;
        x.dly = rnd_dly ? int'($urandom_range(0, 3)) : dly;
        q.push_back(x);
        total += x.dly + 1;
      end
    end
    for (int i = 15; i >= 0; i--) begin
      if (pp[i]) begin
        x.slot = i; x.we = 0; x.addr = sp;
        x.dly = rnd_dly ? int'($urandom_range(0, 3)) : dly;
        if (sp + STEP > 32'hFFFF) wr = 1;
        sp = (sp + STEP) & 32'hFFFF;
        q.push_back(x);
        total += x.dly + 1;
      end
    end
`ifndef STACK_SEQ_WRAP_FLAG_EN
    wr = 0;
`endif
    done_at = total + 1;
    for (int i = 0; i < int'(MASK_W); i++) rf[i] = 16'($urandom);

    @(negedge clk);
    start = 1'b1; push_mask = pm; pop_mask = pp; sp_in = sp0; bus.bus_ack = 1'b0;
    waited = 0; finished = 0;
    for (int c = 1; c <= done_at + 50; c++) begin
      @(negedge clk);
      start = 1'b0; bus.bus_ack = 1'b0;
      push_mask = 16'($urandom); pop_mask = 16'($urandom); sp_in = 16'($urandom);
      if (c == done_at) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_req", bus.bus_req, 0);
        check("final_sp", sp_out, sp);
        check("sp_wrapped", sp_wrapped, wr);
        check("xfers_left", q.size(), 0);
        finished = 1;
        break;
      end
      check("done_early", done, 0);
      check("busy", busy, 1);
      check("req", bus.bus_req, (q.size() != 0));
      if (noise && $urandom_range(0, 3) == 0) start = 1'b1;
      if (q.size() != 0 && bus.bus_req === 1'b1) begin
        check("slot", slot, q[0].slot);
        check("we", bus.bus_we, q[0].we);
        check("addr", bus.bus_addr, q[0].addr);
        if (q[0].we) check("wdata", bus.bus_wdata, rf[q[0].slot]);
        if (waited == q[0].dly) begin
          bus.bus_ack = 1'b1;
          bus.bus_rdata = 16'($urandom);
          #1;
          check("reg_we", reg_we, (!q[0].we && q[0].slot != int'(DISCARD_BIT)));
          if (!q[0].we) check("reg_wdata", reg_wdata, bus.bus_rdata);
          void'(q.pop_front());
          waited = 0;
        end else begin
          waited++;
          #1;
          check("reg_we_wait", reg_we, 0);
        end
      end
    end
    if (!finished) check("done_timeout", 0, 1);
    start = 1'b0;
    // Idle: SP holds, a stray ack without request changes nothing.
    @(negedge clk);
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    check("idle_sp_hold", sp_out, sp);
    check("idle_busy", busy, 0);
    check("idle_req", bus.bus_req, 0);
    check("idle_done", done, 0);
  endtask

  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    for (int i = 0; i < int'(MASK_W); i++) rf[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", bus.bus_req, 0);
    check("rst_we", bus.bus_we, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_sp", sp_out, 0);
    check("rst_slot", slot, 0);
    check("rst_wrap", sp_wrapped, 0);
    reset_n = 1'b1;

    run_seq(16'h01FF, 16'h0000, 16'h0100, 0, 0, 0);  // PUSH R
    run_seq(16'h0000, 16'h01FF, 16'h00EE, 0, 0, 0);  // POP R with discard slot
    run_seq(16'h4C00, 16'h0000, 16'h1234, 3, 0, 0);  // interrupt entry, slow ack
    run_seq(16'h0000, 16'h0000, 16'hBEEF, 0, 0, 0);  // empty masks
    run_seq(16'h0001, 16'h0000, 16'h0000, 0, 0, 0);  // push wrap
    run_seq(16'h0000, 16'h0001, 16'hFFFE, 1, 0, 0);  // pop wrap
    run_seq(16'h8001, 16'h8001, 16'h0002, 0, 0, 1);  // both masks, start noise

    // Reset during the 2nd transfer of a 4-slot push.
    @(negedge clk);
    start = 1'b1; push_mask = 16'h000F; pop_mask = 16'h0000; sp_in = 16'h0200;
    @(negedge clk);
    start = 1'b0; bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    check("mid_addr", bus.bus_addr, 16'h01FC);
    check("mid_slot", slot, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_req", bus.bus_req, 0);
    check("abort_we", bus.bus_we, 0);
    check("abort_sp", sp_out, 0);
    check("abort_slot", slot, 0);
    check("abort_reg_we", reg_we, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_seq(16'h000F, 16'h0003, 16'h0200, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      logic [15:0] pm, pp, sp0;
      pm  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      pp  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      sp0 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom);
      run_seq(pm, pp, sp0, 0, 1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stack_mask_sequencer.md
Name: stack_mask_sequencer

Overview:
- Multi-register stack transfer engine for the V30-class core. Used for PUSH R / POP R, interrupt entry and RETI.
- Takes a push mask and a pop mask in the STACK_* bit encoding. Walks the set bits and issues one word-sized bus transfer per bit through a req/ack handshake.
- Maintains a working SP and steers register-file reads and writes by slot index.
- Parametrised in mask width, data width and SP width. Handles a discard slot during pops.

Parameters:
- MASK_W, 16, number of mask bits (stack slots); slot index width is $clog2(MASK_W)
- DATA_W, 16, transfer width in bits; STEP = DATA_W/8 bytes per transfer
- SP_W, 16, stack-pointer/address width; all SP arithmetic is modulo 2^SP_W
- DISCARD_BIT, 5, mask bit whose pop reads the bus but suppresses the register write (STACK_SP_DISCARD)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  launch sequence; sampled only in IDLE
- push_mask  in  MASK_W  slots to push; sampled on accepted start
- pop_mask  in  MASK_W  slots to pop; sampled on accepted start
- sp_in  in  SP_W  initial SP; sampled on accepted start
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- sp_out  out  SP_W  working SP register
- slot  out  $clog2(MASK_W)  current slot index (register-file select)
- push_data  in  DATA_W  register-file read data for slot (combinational)
- reg_we  out  1  pop write strobe for slot
- reg_wdata  out  DATA_W  pop data (equals bus_rdata)
- bus_req  out  1  transfer request
- bus_we  out  1  1 = write (push), 0 = read (pop)
- bus_addr  out  SP_W  transfer address
- bus_wdata  out  DATA_W  equals push_data
- bus_rdata  in  DATA_W  read data, valid on bus_ack
- bus_ack  in  1  transfer complete
- sp_wrapped  out  1  see Optional Feature

Behaviour:
- Reset values: busy=0, done=0, bus_req=0, bus_we=0, reg_we=0, sp_out=0, slot=0, sp_wrapped=0, state=IDLE. Reset mid-sequence aborts immediately; pending masks are cleared.
- States are IDLE, PUSH, POP, DONE.
- IDLE:
  - start=1 latches masks and sp_in into sp_out, then sets busy=1.
  - Next state is PUSH if push_mask≠0, else POP if pop_mask≠0, else DONE.
- PUSH:
  - Selects the lowest set bit of the remaining push mask as slot.
  - bus_req=1, bus_we=1, bus_addr = sp_out − STEP.
  - On bus_ack: sp_out ← sp_out − STEP and the bit is cleared.
  - When the remaining mask becomes 0, go to POP if pop mask ≠ 0, else DONE.
- POP:
  - Selects the highest set bit of the remaining pop mask as slot.
  - bus_req=1, bus_we=0, bus_addr = sp_out.
  - On bus_ack: reg_we=1 in that same cycle (combinational with ack), unless slot==DISCARD_BIT. Then sp_out ← sp_out + STEP and the bit is cleared.
  - When the remaining mask becomes 0, go to DONE.
- DONE: done=1 for one cycle, busy=0 in that cycle, then IDLE. sp_out holds its final value until the next start.
- Handshake:
  - bus_req, bus_we, bus_addr and slot stay stable while waiting for ack.
  - bus_req may stay high across back-to-back transfers; the next address appears the cycle after ack.
  - bus_ack while bus_req=0 is ignored.
- Latency:
  - N transfers with single-cycle ack: done is asserted N+1 cycles after the start cycle.
  - Empty masks: done one cycle after start; no bus activity.
- start while busy is ignored.
- Both masks set: all pushes complete before any pop.
- SP wraps modulo 2^SP_W (push from 0x0000 with STEP=2 uses address 0xFFFE).

Optional Feature:
- STACK_SEQ_WRAP_FLAG_EN defined:
  - sp_wrapped is a sticky flag. It sets when any SP update in the current sequence crosses the 0/2^SP_W boundary, in either direction.
  - It clears on an accepted start and is valid alongside done.
- Not defined: sp_wrapped is tied to 0 and no wrap-detection logic is built. SP wrap arithmetic is unchanged.

Test Plan:
- PUSH R: push_mask=0x01FF, sp_in=0x0100, ack each cycle → 9 writes at 0x00FE..0x00EE with slot 0..8 ascending; sp_out=0x00EE; done 10 cycles after start.
- POP R: pop_mask=0x01FF, sp_in=0x00EE → 9 reads at 0x00EE..0x00FE with slot 8..0 descending; reg_we absent for slot 5 only; sp_out=0x0100.
- Interrupt entry: push_mask=0x4C00, ack delayed 3 cycles each → slots 10, 11, 14 in order; request signals stable during waits; sp_out decreases by 6.
- Empty masks with start → done the next cycle, bus_req never asserted, sp_out=sp_in.
- Wrap: push_mask=0x0001, sp_in=0x0000 → bus_addr=0xFFFE; with STACK_SEQ_WRAP_FLAG_EN, sp_wrapped=1 at done, otherwise 0.
- Reset: reset_n low during the 2nd transfer of a 4-slot push → outputs return to reset values immediately; a fresh start afterwards runs a full sequence.
